output_partial_sum_accumulator: RTL

// - Consumes the (row, column) output coordinates produced by the coordinate-computation stage,

---
 rtl/output_partial_sum_accumulator_if.sv | 35 +++
 rtl/output_partial_sum_accumulator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/output_partial_sum_accumulator_if.sv
// Batch-in / tile-out bundle for the output partial-sum accumulator.
// The master modport drives batches and drain requests; the slave modport is the accumulator.
interface output_partial_sum_accumulator_if #(
  parameter int LANES = 16,
  parameter int PW    = 32,
  parameter int DW    = 6
);
  logic [DW-1:0]       out_dim;
  logic                in_valid;
  logic                in_ready;
  logic [LANES-1:0]    in_lane_valid;
  logic [LANES*16-1:0] in_row;
  logic [LANES*16-1:0] in_col;
  logic [LANES*PW-1:0] in_product;
  logic                drain_req;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_row;
  logic [DW-1:0]       out_col;
  logic [PW-1:0]       out_data;
  logic                out_last;
  logic                drain_done;
  logic                busy;
  logic [15:0]         drop_count;

  modport master (
    output out_dim, in_valid, in_lane_valid, in_row, in_col, in_product, drain_req, out_ready,
    input  in_ready, out_valid, out_row, out_col, out_data, out_last, drain_done, busy, drop_count
  );

  modport slave (
    input  out_dim, in_valid, in_lane_valid, in_row, in_col, in_product, drain_req, out_ready,
    output in_ready, out_valid, out_row, out_col, out_data, out_last, drain_done, busy, drop_count
  );
endinterface

// File: rtl/output_partial_sum_accumulator.sv
// Scatter-accumulates masked, bounds-checked lane products into a D x D partial-sum tile,
// one lane per cycle, then streams the tile out in raster order while clearing it.
module output_partial_sum_accumulator #(
  parameter int LANES   = 16,
  parameter int PW      = 32,
  parameter int OUT_MAX = 32,
  parameter int DW      = $clog2(OUT_MAX + 1)
) (
  input logic                          clk,
  input logic                          reset,
  output_partial_sum_accumulator_if.slave bus
);
  localparam int CW = $clog2(OUT_MAX);
  localparam int AW = $clog2(OUT_MAX * OUT_MAX);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DRAIN = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    acc_q [OUT_MAX*OUT_MAX];
  logic [LANES-1:0] keep_q;
  logic [CW-1:0]    lrow_q [LANES];
  logic [CW-1:0]    lcol_q [LANES];
  logic [PW-1:0]    lprod_q [LANES];
  logic [DW-1:0]    dim_q;
  logic             drain_pending_q;
  logic [15:0]      drop_count_q;
  logic [AW:0]      addr_q;
  logic [DW-1:0]    drow_q, dcol_q;
  logic             out_valid_q, out_last_q, drain_done_q;
  logic [DW-1:0]    out_row_q, out_col_q;
  logic [PW-1:0]    out_data_q;

  logic             in_ready_s, busy_s, accept_s, drain_start_s, load_s, last_hs_s, tile_end_s;
  logic [LANES-1:0] keep_s, drop_s, keep_next_s;
  logic [LW:0]      drop_cnt_s;
  logic [16:0]      drop_sum_s;
  logic [15:0]      drop_next_s, row_s, col_s;
  logic [14:0]      dim_ext_s;
  logic [LW-1:0]    idx_s;
  logic [AW-1:0]    scan_addr_s;

  // Output decode: batches only when idle and no drain is being started
  always_comb begin
    in_ready_s = (state_q == S_IDLE) && !bus.drain_req && !drain_pending_q;
    busy_s     = (state_q != S_IDLE);
  end

  // Per-lane bounds check against the live tile dimension, plus saturating drop tally
  always_comb begin
    keep_s     = '0;
    drop_s     = '0;
    drop_cnt_s = '0;
    row_s      = '0;
    col_s      = '0;
    dim_ext_s  = {{(15-DW){1'b0}}, bus.out_dim};
    for (int i = 0; i < LANES; i++) begin
      row_s      = bus.in_row[i*16 +: 16];
      col_s      = bus.in_col[i*16 +: 16];
      keep_s[i]  = bus.in_lane_valid[i] && !row_s[15] && (row_s[14:0] < dim_ext_s)
                   && !col_s[15] && (col_s[14:0] < dim_ext_s);
      drop_s[i]  = bus.in_lane_valid[i] && !keep_s[i];
      drop_cnt_s = drop_cnt_s + (LW+1)'(drop_s[i]);
    end
    drop_sum_s  = {1'b0, drop_count_q} + 17'(drop_cnt_s);
    drop_next_s = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
  end

  // Lowest pending lane and its flat tile address
  always_comb begin
    idx_s = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      idx_s = keep_q[i] ? LW'(i) : idx_s;
    end
    keep_next_s = keep_q & (keep_q - LANES'(1));
    scan_addr_s = {{(AW-CW){1'b0}}, lrow_q[idx_s]} * {{(AW-DW){1'b0}}, dim_q}
                  + {{(AW-CW){1'b0}}, lcol_q[idx_s]};
  end

  // Handshake and drain sequencing strobes
  always_comb begin
    accept_s      = bus.in_valid && in_ready_s;
    drain_start_s = ((state_q == S_IDLE) && (bus.drain_req || drain_pending_q))
                    || ((state_q == S_SCAN) && (keep_next_s == '0) && drain_pending_q);
    last_hs_s     = (state_q == S_DRAIN) && out_valid_q && bus.out_ready && out_last_q;
    load_s        = (state_q == S_DRAIN) && (!out_valid_q || (bus.out_ready && !out_last_q));
    tile_end_s    = (drow_q == dim_q - DW'(1)) && (dcol_q == dim_q - DW'(1));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.drain_req || drain_pending_q) begin
          state_d = S_DRAIN;
        end else if (accept_s && (keep_s != '0)) begin
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (keep_next_s == '0) begin
          state_d = drain_pending_q ? S_DRAIN : S_IDLE;
        end else begin
          state_d = S_SCAN;
        end
      end
      S_DRAIN: begin
        if (last_hs_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: batch capture, serial accumulate, drain load-and-clear
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < OUT_MAX*OUT_MAX; k++) acc_q[k] <= '0;
      for (int i = 0; i < LANES; i++) begin
        lrow_q[i]  <= '0;
        lcol_q[i]  <= '0;
        lprod_q[i] <= '0;
      end
      keep_q          <= '0;
      dim_q           <= '0;
      drain_pending_q <= 1'b0;
      drop_count_q    <= '0;
      addr_q          <= '0;
      drow_q          <= '0;
      dcol_q          <= '0;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
      out_row_q       <= '0;
      out_col_q       <= '0;
      out_data_q      <= '0;
      drain_done_q    <= 1'b0;
    end else begin
      drain_done_q <= 1'b0;
      if (drain_start_s) begin
        dim_q           <= bus.out_dim;
        drow_q          <= '0;
        dcol_q          <= '0;
        addr_q          <= '0;
        drain_pending_q <= 1'b0;
      end else if (accept_s) begin
        dim_q        <= bus.out_dim;
        keep_q       <= keep_s;
        drop_count_q <= drop_next_s;
        for (int i = 0; i < LANES; i++) begin
          lrow_q[i]  <= bus.in_row[i*16 +: CW];
          lcol_q[i]  <= bus.in_col[i*16 +: CW];
          lprod_q[i] <= bus.in_product[i*PW +: PW];
        end
      end else if ((state_q == S_SCAN) && bus.drain_req) begin
        drain_pending_q <= 1'b1;
      end
      if (state_q == S_SCAN) begin
        acc_q[scan_addr_s] <= acc_q[scan_addr_s] + lprod_q[idx_s];
        keep_q             <= keep_next_s;
      end
      // The sum is cleared as it moves into the output register; the tile is only reused after drain_done
      if (load_s) begin
        out_valid_q              <= 1'b1;
        out_row_q                <= drow_q;
        out_col_q                <= dcol_q;
        out_data_q               <= acc_q[addr_q[AW-1:0]];
        out_last_q               <= tile_end_s;
        acc_q[addr_q[AW-1:0]]    <= '0;
        addr_q                   <= addr_q + (AW+1)'(1);
        if (dcol_q == dim_q - DW'(1)) begin
          dcol_q <= '0;
          drow_q <= drow_q + DW'(1);
        end else begin
          dcol_q <= dcol_q + DW'(1);
        end
      end else if (last_hs_s) begin
        out_valid_q  <= 1'b0;
        out_last_q   <= 1'b0;
        drain_done_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.busy       = busy_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.drain_done = drain_done_q;
  assign bus.drop_count = drop_count_q;
endmodule
